// File: rtl/pipe_pkg.sv
// Shared types and default widths for the in-order core's stage registers.
package pipe_pkg;

  // Occupancy state of a stage register. The 2'b11 encoding is unused and
  // recovers to PS_EMPTY.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'b00,
    PS_BUSY  = 2'b01,
    PS_FULL  = 2'b10
  } pipe_state_e;

  // Default payload widths at each stage boundary.
  localparam int IF_ID_CTRL_W  = 8;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 16;
  localparam int ID_EX_DATA_W  = 128;
  localparam int EX_MEM_CTRL_W = 12;
  localparam int EX_MEM_DATA_W = 96;
  localparam int MEM_WB_CTRL_W = 8;
  localparam int MEM_WB_DATA_W = 64;

  // Entries held for a given state; illegal encodings report empty.
  function automatic logic [1:0] state_occ(input pipe_state_e s);
    case (s)
      PS_BUSY: state_occ = 2'd1;
      PS_FULL: state_occ = 2'd2;
      default: state_occ = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable/clear register over a {ctrl, data} payload. Clear always zeroes the
// control word; the data word is zeroed on clear only when CLR_DATA=1.
module pipe_payload_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 16,
  parameter int DATA_W   = 128,
  parameter int CLR_DATA = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              en,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // Control word: reset > clear > load.
  always_ff @(posedge clk) begin
    if (!rstn)     q_ctrl <= '0;
    else if (clr)  q_ctrl <= '0;
    else if (en)   q_ctrl <= d_ctrl;
  end

  generate
    if (CLR_DATA != 0) begin : g_data_clr
      // Data word zeroed on clear.
      always_ff @(posedge clk) begin
        if (!rstn)     q_data <= '0;
        else if (clr)  q_data <= '0;
        else if (en)   q_data <= d_data;
      end
    end else begin : g_data_hold
      // Data word holds across a clear; a stale value is harmless because
      // the gated control word marks the bubble.
      always_ff @(posedge clk) begin
        if (!rstn)                q_data <= '0;
        else if (en && !clr)      q_data <= d_data;
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and
// an optional 2-entry skid buffer that registers in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = ID_EX_CTRL_W,
  parameter int DATA_W   = ID_EX_DATA_W,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  pipe_state_e       state_q, state_d;
  logic              in_fire, out_fire;
  logic              main_en, main_from_skid, skid_en;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;

  assign out_valid = (state_q == PS_BUSY) || (state_q == PS_FULL);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occ       = state_occ(state_q);

  generate
    if (SKID != 0) begin : g_rdy_reg
      // Ready decoded from state only: no path from out_ready to in_ready.
      assign in_ready = (state_q == PS_EMPTY) || (state_q == PS_BUSY);
    end else begin : g_rdy_comb
      // Single register: accept when empty or when the held entry leaves.
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  // State register: reset > flush > normal next state.
  always_ff @(posedge clk) begin
    if (!rstn)      state_q <= PS_EMPTY;
    else if (flush) state_q <= PS_EMPTY;
    else            state_q <= state_d;
  end

  // Next-state and main-register load decode.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      PS_EMPTY: begin
        if (in_fire) begin
          state_d = PS_BUSY;
          main_en = 1'b1;
        end
      end
      PS_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          // Only reachable with the skid buffer; without it in_ready
          // already implies out_fire here.
          if (SKID != 0) state_d = PS_FULL;
          else           main_en = 1'b1;
        end else if (out_fire) begin
          state_d = PS_EMPTY;
        end
      end
      PS_FULL: begin
        if (out_fire) begin
          state_d        = PS_BUSY;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
  end

  // Main refills from the skid entry when draining FULL, else from upstream.
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  pipe_payload_reg #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CLR_DATA (CLR_DATA)
  ) u_main (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (flush),
    .en     (main_en),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .q_ctrl (main_ctrl),
    .q_data (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      // Second entry captured when upstream fires into a stalled BUSY stage.
      assign skid_en = (state_q == PS_BUSY) && in_fire && !out_fire;

      pipe_payload_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR_DATA)
      ) u_skid (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (flush),
        .en     (skid_en),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
      );
    end else begin : g_noskid
      assign skid_en   = 1'b0;
      assign skid_ctrl = '0;
      assign skid_data = '0;
    end
  endgenerate

  // Bubbles carry no control bits so downstream write enables stay low.
  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
  assign out_data = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three variants (skid, no skid, skid + data clear)
// driven with identical stimulus, each checked against a FIFO-level model.
module tb_pipe_stage_reg;

  localparam int CW = 16;
  localparam int DW = 32;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rstn, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready  [NI];
  logic          out_valid [NI];
  logic [CW-1:0] out_ctrl  [NI];
  logic [DW-1:0] out_data  [NI];
  logic [1:0]    occ       [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each instance is a FIFO of capacity 2 (skid) or 1 (no skid);
  // lh is the data word last presented at the head.
  logic [CW-1:0] mc [NI][2];
  logic [DW-1:0] md [NI][2];
  int            mn [NI];
  logic [DW-1:0] lh [NI];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(0)) u_s1 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_ctrl(out_ctrl[0]), .out_data(out_data[0]), .occ(occ[0]));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLR_DATA(0)) u_s0 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_ctrl(out_ctrl[1]), .out_data(out_data[1]), .occ(occ[1]));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(1)) u_s1c (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_ctrl(out_ctrl[2]), .out_data(out_data[2]), .occ(occ[2]));

  function automatic bit skid_of(input int i);
    return i != 1;
  endfunction

  function automatic bit clr_of(input int i);
    return i == 2;
  endfunction

  function automatic bit exp_ir(input int i);
    if (skid_of(i)) return mn[i] < 2;
    return (mn[i] == 0) || out_ready;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check all instances mid-cycle, advance model.
  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic [CW-1:0] c, input logic o);
    bit ifr, ofr;
    rstn = r; flush = f; in_valid = v; in_ctrl = c; out_ready = o;
    in_data = $urandom;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("in_ready[%0d]", i),  in_ready[i],  exp_ir(i));
      chk($sformatf("out_valid[%0d]", i), out_valid[i], mn[i] > 0);
      chk($sformatf("out_ctrl[%0d]", i),  out_ctrl[i],  (mn[i] > 0) ? mc[i][0] : '0);
      chk($sformatf("out_data[%0d]", i),  out_data[i],  (mn[i] > 0) ? md[i][0] : lh[i]);
      chk($sformatf("occ[%0d]", i),       occ[i],       mn[i]);
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (!rstn) begin
        mn[i] = 0; lh[i] = '0;
      end else if (flush) begin
        mn[i] = 0;
        if (clr_of(i)) lh[i] = '0;
      end else begin
        ifr = in_valid && exp_ir(i);
        ofr = (mn[i] > 0) && out_ready;
        if (ofr) begin
          mc[i][0] = mc[i][1]; md[i][0] = md[i][1]; mn[i]--;
        end
        if (ifr) begin
          mc[i][mn[i]] = in_ctrl; md[i][mn[i]] = in_data; mn[i]++;
        end
        if (mn[i] > 0) lh[i] = md[i][0];
      end
    end
    #1;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    for (int i = 0; i < NI; i++) begin
      mn[i] = 0; lh[i] = '0;
      mc[i][0] = '0; mc[i][1] = '0; md[i][0] = '0; md[i][1] = '0;
    end
    @(posedge clk); #1;

    // Reset then stream 1..5 unstalled.
    cyc(0, 0, 1, 16'h0BAD, 1);
    cyc(0, 0, 1, 16'h0BAD, 1);
    for (int k = 1; k <= 5; k++) cyc(1, 0, 1, CW'(k), 1);
    cyc(1, 0, 0, '0, 1);
    cyc(1, 0, 0, '0, 1);

    // Backpressure: A, B, C with downstream stalled, C re-presented.
    cyc(1, 0, 1, 16'h000A, 0);
    cyc(1, 0, 1, 16'h000B, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 16'h000C, 0);
    cyc(1, 0, 0, '0, 1);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, '0, 1);

    // Flush while FULL with an input offered the same cycle.
    cyc(1, 0, 1, 16'h00A1, 0);
    cyc(1, 0, 1, 16'h00A2, 0);
    cyc(1, 1, 1, 16'h00FF, 0);
    cyc(1, 0, 0, '0, 1);
    cyc(1, 0, 0, '0, 1);

    // Simultaneous in/out fire in BUSY.
    cyc(1, 0, 1, 16'h0011, 0);
    cyc(1, 0, 1, 16'h0022, 1);
    cyc(1, 0, 0, '0, 1);
    cyc(1, 0, 0, '0, 1);

    // Combinational ready without skid: stall then release.
    cyc(1, 0, 1, 16'h0033, 0);
    cyc(1, 0, 1, 16'h0044, 0);
    cyc(1, 0, 1, 16'h0044, 1);
    cyc(1, 0, 0, '0, 1);
    cyc(1, 0, 0, '0, 1);

    // Reset while FULL.
    cyc(1, 0, 1, 16'h0055, 0);
    cyc(1, 0, 1, 16'h0066, 0);
    cyc(0, 0, 1, 16'h0077, 0);
    cyc(1, 0, 0, '0, 0);
    cyc(1, 0, 0, '0, 1);

    // Random traffic.
    for (int k = 0; k < 1500; k++)
      cyc(($urandom_range(99) != 0), ($urandom_range(19) == 0),
          ($urandom_range(9) < 7), CW'($urandom), ($urandom_range(9) < 6));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed decode/execute register.
- Carries an arbitrary control word and data word between any two stages with a valid/ready handshake, a synchronous flush, and an optional 2-entry skid buffer.
- With the skid buffer, in_ready is registered, so backpressure does not form a combinational path back through the pipe.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB in the in-order core.

Parameters:
- CTRL_W, 16: width of control payload. Zeroed on flush and whenever out_valid=0.
- DATA_W, 128: width of data payload (operands, pc, imm, register addresses).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLR_DATA, 0: 1 = data payload is also zeroed on flush; 0 = data holds its value.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- flush  in  1  kill all held entries (branch mispredict / trap)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control word
- in_data  in  DATA_W  upstream data word
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control word, 0 when out_valid=0
- out_data  out  DATA_W  data word
- occ  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid registers=0, occ=0.
  - in_ready=1 (decoded from EMPTY); inputs are ignored while rstn=0.
- Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Priority per edge: reset > flush > normal operation.
- Flush:
  - Next state EMPTY; all valids cleared; ctrl registers zeroed.
  - Data registers zeroed only if CLR_DATA=1.
  - An in_fire in the same cycle is dropped.
  - out_valid=0 from the next cycle; in_ready=1 next cycle.
- SKID=1 state machine (states from the package enum):
  - EMPTY: in_ready=1. in_fire -> BUSY, main<=in.
  - BUSY: in_ready=1.
    - in_fire & !out_fire -> FULL, skid<=in.
    - !in_fire & out_fire -> EMPTY.
    - in_fire & out_fire -> BUSY, main<=in.
    - neither -> hold.
  - FULL: in_ready=0.
    - out_fire -> BUSY, main<=skid.
    - otherwise hold; main and skid are stable.
  - in_ready is a function of state only; no path from out_ready.
  - Latency: 1 cycle in to out when unstalled. Throughput: 1 per cycle with out_ready held high.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On in_fire: main<=in, out_valid<=1.
  - On out_fire without in_fire: out_valid<=0.
- Output gating:
  - out_ctrl = main_ctrl & {CTRL_W{out_valid}}, so downstream stages see bubbles with no write enables set.
  - out_data is always driven from main.
- Stall: out_valid=1 & out_ready=0 holds out_ctrl and out_data bit-stable until out_fire or flush.
- occ: EMPTY=0, BUSY=1, FULL=2. Updated the same edge as state.
- Illegal/undefined state encoding: recovers to EMPTY on the next edge.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] pipe_state_e {PS_EMPTY, PS_BUSY, PS_FULL}.
  - Default width localparams for each stage boundary (e.g. ID_EX_CTRL_W, ID_EX_DATA_W).
- Sub-module pipe_payload_reg:
  - Enable/clear register over {ctrl, data}, with a CLR_DATA generate.
  - Instantiated as main and, under the SKID generate, as skid.

Test Plan:
- Reset then stream, SKID=1: rstn=0 for 2 cycles, then ctrl=0x0001..0x0005 on consecutive cycles with out_ready=1 -> out_valid rises the cycle after the first in_fire; ctrl values appear in order, 1 per cycle; occ=1 throughout.
- Backpressure, SKID=1:
  - Stream A, B, C with out_ready=0 from the cycle A is presented.
  - Required: occ goes 1 then 2; in_ready=0 after B is captured; C is held off; out_ctrl stays A.
  - Raise out_ready: output order A, B, C; nothing lost or duplicated.
- Flush in FULL, CLR_DATA=0: flush=1 together with in_valid=1 (ctrl=0x00FF) -> next cycle out_valid=0, out_ctrl=0x0000, occ=0, out_data unchanged, 0x00FF never emerges.
- Simultaneous in and out fire in BUSY: main=0x0011, in=0x0022, out_ready=1 -> next cycle out_ctrl=0x0022, occ=1, state BUSY.
- SKID=0 pass-through: out_ready=0 while holding 0x0033 -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 (0x0044) -> in_ready=1 combinationally; 0x0044 appears the next cycle.
- Reset mid-operation: rstn=0 while FULL with flush=0 -> next cycle occ=0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
